// File: rtl/div3_residue_tx.sv
// ============================================================================
// Module   : div3_residue_tx
// Purpose  : MSB-first serial transmitter for the divide-by-3 residue link.
//            Tracks the running remainder mod 3 and, when DIV3_TX_CHECK_EN is
//            defined, appends two check bits so each frame is divisible by 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div3_residue_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic [1:0]        residue
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
`ifndef DIV3_TX_CHECK_EN
    localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(DATA_W - 2);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        residue_q;
    logic              out_bit_q;
    logic              out_valid_q;
    logic              out_first_q;
    logic              out_last_q;
    logic              in_ready_q;
    logic [1:0]        residue_d;

    // Appending bit b to a value with remainder r gives remainder (2r + b) mod 3.
    function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            2'd0:    n = {1'b0, b};
            2'd1:    n = b ? 2'd0 : 2'd2;
            2'd2:    n = b ? 2'd2 : 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    assign residue_d = res_step(residue_q, out_bit_q);

`ifdef DIV3_TX_CHECK_EN
    logic       chk_lsb_q;
    logic       chk_idx_q;
    logic [1:0] chk_d;

    // Two appended bits are worth t mod 3 because 4 == 1 (mod 3).
    always_comb begin
        chk_d = 2'b00;
        case (residue_d)
            2'd1:    chk_d = 2'b10;
            2'd2:    chk_d = 2'b01;
            default: chk_d = 2'b00;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            residue_q   <= 2'd0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef DIV3_TX_CHECK_EN
            chk_lsb_q   <= 1'b0;
            chk_idx_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    if (in_valid && in_ready_q) begin
                        shreg_q     <= {in_data[DATA_W-2:0], 1'b0};
                        cnt_q       <= '0;
                        residue_q   <= 2'd0;
                        out_bit_q   <= in_data[DATA_W-1];
                        out_valid_q <= 1'b1;
                        out_first_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (out_ready) begin
                        residue_q   <= residue_d;
                        out_first_q <= 1'b0;
                        shreg_q     <= shreg_q << 1;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_IDX) begin
`ifdef DIV3_TX_CHECK_EN
                            chk_lsb_q  <= chk_d[0];
                            chk_idx_q  <= 1'b0;
                            out_bit_q  <= chk_d[1];
                            out_last_q <= 1'b0;
                            state_q    <= ST_CHK;
`else
                            out_bit_q   <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_IDLE;
`endif
                        end else begin
                            out_bit_q <= shreg_q[DATA_W-1];
`ifndef DIV3_TX_CHECK_EN
                            out_last_q <= (cnt_q == PENULT_IDX);
`endif
                        end
                    end
                end

`ifdef DIV3_TX_CHECK_EN
                ST_CHK: begin
                    if (out_ready) begin
                        residue_q <= residue_d;
                        if (!chk_idx_q) begin
                            out_bit_q  <= chk_lsb_q;
                            out_last_q <= 1'b1;
                            chk_idx_q  <= 1'b1;
                        end else begin
                            out_bit_q   <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            chk_idx_q   <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
`endif

                default: begin
                    state_q     <= ST_IDLE;
                    out_bit_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_first_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    residue_q   <= 2'd0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign residue   = residue_q;

endmodule

`default_nettype wire

// File: doc/div3_residue_tx.md
# div3_residue_tx

- Serial transmitter for the divide-by-3 residue link.
- Accepts a parallel word, shifts it out MSB-first and tracks the running remainder mod 3.
- Appends two check bits so the whole frame, read as a binary number, is divisible by 3.
- Sits upstream of the divide-by-3 remainder FSM: a clean frame leaves that FSM in remainder 0.

## Interface

Parameters:
- DATA_W, default 8: payload width in bits, minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_data  input  DATA_W  payload word; captured on accept.
- in_valid  input  1  payload word offered.
- in_ready  output  1  block can accept a word; high only in IDLE.
- out_bit  output  1  current serial bit.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream takes out_bit this cycle.
- out_first  output  1  current beat is the frame's first beat (payload MSB).
- out_last  output  1  current beat is the frame's final beat.
- residue  output  2  running remainder mod 3 of beats already accepted in this frame; values 0..2 only.

## Operation

- Beat accepted: out_valid && out_ready on a rising edge.
- Word accepted: in_valid && in_ready on a rising edge.
- States:
  - IDLE: in_ready=1, out_valid=0. Word accepted → load shift register with in_data, clear residue, go to DATA.
  - DATA: out_valid=1, out_bit = shift register MSB.
    - Each accepted beat: shift left, bit counter +1, residue ← (2·residue + out_bit) mod 3.
    - After beat DATA_W−1 is accepted, go to CHK.
  - CHK: two beats.
    - Check value t = (3 − residue) mod 3, latched on entry: residue 0→00, 1→10, 2→01. Sent MSB first.
    - Valid because 4 ≡ 1 (mod 3): frame value = 4·V + t ≡ V + t ≡ 0.
    - residue keeps updating on CHK beats and reads 0 after the final beat.
    - After the second accepted beat, go to IDLE.
- Frame length is DATA_W+2 beats.
- out_first is high on beat 0 only; out_last is high on the final beat only.
- While out_valid && !out_ready: out_bit, out_first, out_last and residue hold; no state change.
- in_data changes after a word is accepted do not affect the frame in flight.
- Unreachable state encodings recover to IDLE with outputs cleared.

## Timing

- Reset values: in_ready=0 while rst_n low, then 1 from the first edge after release. out_valid=0, out_bit=0, out_first=0, out_last=0, residue=0, state IDLE.
- rst_n asserted mid-frame: all outputs clear immediately (asynchronously); the partial frame is abandoned and no check bits are sent.
- All outputs are registered; no combinational path from any input to any output.
- Latency: out_valid rises the cycle after the word-accept edge, presenting the MSB.
- Minimum frame period with out_ready held high: DATA_W+3 cycles (DATA_W+2 beats plus one IDLE cycle). No back-to-back frames.
- residue reflects beats accepted up to and including the previous edge.

## Configuration

- Macro: DIV3_TX_CHECK_EN.
- Defined: two check bits appended as above; frame length DATA_W+2; out_last on the second check beat.
- Undefined:
  - CHK state is not built; frame length is DATA_W; out_last is on the payload LSB.
  - residue still tracks and ends at in_data mod 3.
  - The block is a plain MSB-first serializer.

## Test plan

All scenarios use DATA_W=8 and DIV3_TX_CHECK_EN defined unless stated.

- in_data=0x05, out_ready=1: stream 0000010101, check bits 01, out_last on beat 9; residue ends 0; downstream remainder FSM ends in 0.
- in_data=0x07 → check bits 10; in_data=0xFF → check bits 00. Frame values are 30 and 1020, both divisible by 3.
- in_data=0xA5, out_ready low for 3 cycles at beat 4: out_bit, residue and out_last are stable during the stall; the completed stream is unchanged vs. the no-stall run; in_ready stays low until after the final beat.
- rst_n pulsed low during beat 6 of 0x3C: out_valid drops without a clock edge. After release, in_ready=1 and a new word 0x01 produces 0000000110.
- in_valid held high with two words queued: second word accepted only in IDLE, DATA_W+3 cycles after the first; no beat overlap.
- DIV3_TX_CHECK_EN undefined, in_data=0x05: exactly 8 beats 00000101, out_last on beat 7, final residue=2.
